mult_pipe: RTL and testbench

Parametrised, fully pipelined integer multiply functional unit for the out-of-order core. It accepts one RV32M multiply per cycle from the issue stage and carries a destination physical tag and branch mask with each op. It delivers results in order to the complete/CDB stage after a fixed `STAGES`-cycle latency. Relative to the single-op `mult` unit it adds back-to-back issue, per-stage bubble collapsing under downstream stall, and branch-mask squash/resolve of in-flight ops.

---
 rtl/mult_pipe_if.sv | 36 +++
 rtl/mult_pipe.sv | 179 +++++++++++++++++
 tb/tb_mult_pipe.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pipe_if.sv
// Issue, completion and branch-control bundle for mult_pipe.
// The issue stage drives the master side; the multiply unit uses the slave side.
interface mult_pipe_if #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  parameter int BMASK_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_func;
  logic [XLEN-1:0]    in_rs1;
  logic [XLEN-1:0]    in_rs2;
  logic [TAG_W-1:0]   in_tag;
  logic [BMASK_W-1:0] in_bmask;
  logic               stall;
  logic               squash_en;
  logic [BMASK_W-1:0] squash_mask;
  logic               resolve_en;
  logic [BMASK_W-1:0] resolve_mask;
  logic               out_valid;
  logic [XLEN-1:0]    out_result;
  logic [TAG_W-1:0]   out_tag;
  logic [BMASK_W-1:0] out_bmask;

  modport master (
    output in_valid, in_func, in_rs1, in_rs2, in_tag, in_bmask,
    output stall, squash_en, squash_mask, resolve_en, resolve_mask,
    input  in_ready, out_valid, out_result, out_tag, out_bmask
  );

  modport slave (
    input  in_valid, in_func, in_rs1, in_rs2, in_tag, in_bmask,
    input  stall, squash_en, squash_mask, resolve_en, resolve_mask,
    output in_ready, out_valid, out_result, out_tag, out_bmask
  );
endinterface

// File: rtl/mult_pipe.sv
// Fully pipelined RV32M multiply unit: XLEN/STAGES multiplier bits per stage, in-order results.
// Define MULT_PIPE_BRANCH_EN to keep per-stage branch masks with squash/resolve support.
module mult_pipe #(
  parameter int XLEN    = 32,
  parameter int STAGES  = 4,
  parameter int TAG_W   = 6,
  parameter int BMASK_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  mult_pipe_if.slave bus
);
  localparam int CW   = XLEN / STAGES;
  localparam int PW   = 2 * XLEN;
  localparam int LAST = STAGES - 1;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [2:0]        func_q   [STAGES];
  logic [2:0]        func_d   [STAGES];
  logic [TAG_W-1:0]  tag_q    [STAGES];
  logic [TAG_W-1:0]  tag_d    [STAGES];
  logic [PW-1:0]     mcand_q  [STAGES];
  logic [PW-1:0]     mcand_d  [STAGES];
  logic [XLEN-1:0]   mplier_q [STAGES];
  logic [XLEN-1:0]   mplier_d [STAGES];
  logic [PW-1:0]     psum_q   [STAGES];
  logic [PW-1:0]     psum_d   [STAGES];

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] kill;
  logic              kill_in;

  function automatic logic [PW-1:0] step_sum(input logic [PW-1:0]   sum,
                                             input logic [PW-1:0]   mc,
                                             input logic [XLEN-1:0] mp);
    return sum + mc * {{(PW-CW){1'b0}}, mp[CW-1:0]};
  endfunction

  logic            rs1_signed;
  logic            rs2_signed;
  logic [PW-1:0]   rs1_ext;
  logic [PW-1:0]   psum_init;

  assign rs1_signed = (bus.in_func == M_MULH) || (bus.in_func == M_MULHSU);
  assign rs2_signed = (bus.in_func == M_MULH);
  assign rs1_ext    = rs1_signed ? {{XLEN{bus.in_rs1[XLEN-1]}}, bus.in_rs1}
                                 : {{XLEN{1'b0}}, bus.in_rs1};

  // Only the low XLEN multiplier bits are walked; a negative signed rs2 owes
  // -rs1_ext * 2^XLEN, which is preloaded into the partial sum instead.
  assign psum_init = (rs2_signed && bus.in_rs2[XLEN-1]) ? ({PW{1'b0}} - (rs1_ext << XLEN))
                                                        : {PW{1'b0}};

  always_comb begin
    adv       = '0;
    adv[LAST] = !valid_q[LAST] || !bus.stall;
    for (int i = LAST - 1; i >= 0; i--) begin
      adv[i] = !valid_q[i] || adv[i+1];
    end
  end

  assign bus.in_ready = adv[0];

  always_comb begin
    valid_d  = valid_q;
    func_d   = func_q;
    tag_d    = tag_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    psum_d   = psum_q;
    if (adv[0]) begin
      valid_d[0]  = bus.in_valid && !kill_in;
      func_d[0]   = bus.in_func;
      tag_d[0]    = bus.in_tag;
      mcand_d[0]  = rs1_ext << CW;
      mplier_d[0] = bus.in_rs2 >> CW;
      psum_d[0]   = step_sum(psum_init, rs1_ext, bus.in_rs2);
    end else begin
      valid_d[0] = valid_q[0] && !kill[0];
    end
    for (int i = 1; i < STAGES; i++) begin
      if (adv[i]) begin
        valid_d[i]  = valid_q[i-1] && !kill[i-1];
        func_d[i]   = func_q[i-1];
        tag_d[i]    = tag_q[i-1];
        mcand_d[i]  = mcand_q[i-1] << CW;
        mplier_d[i] = mplier_q[i-1] >> CW;
        psum_d[i]   = step_sum(psum_q[i-1], mcand_q[i-1], mplier_q[i-1]);
      end else begin
        valid_d[i] = valid_q[i] && !kill[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        func_q[i]   <= '0;
        tag_q[i]    <= '0;
        mcand_q[i]  <= '0;
        mplier_q[i] <= '0;
        psum_q[i]   <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      func_q   <= func_d;
      tag_q    <= tag_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      psum_q   <= psum_d;
    end
  end

`ifdef MULT_PIPE_BRANCH_EN
  logic [BMASK_W-1:0] bmask_q [STAGES];
  logic [BMASK_W-1:0] bmask_d [STAGES];
  logic [BMASK_W-1:0] keep_mask;

  assign keep_mask = bus.resolve_en ? ~bus.resolve_mask : {BMASK_W{1'b1}};
  assign kill_in   = bus.squash_en && (|(bus.in_bmask & bus.squash_mask));

  // Squash looks at the pre-resolve mask; resolve only shapes what is stored.
  always_comb begin
    kill = '0;
    for (int i = 0; i < STAGES; i++) begin
      kill[i] = bus.squash_en && (|(bmask_q[i] & bus.squash_mask));
    end
  end

  always_comb begin
    bmask_d    = bmask_q;
    bmask_d[0] = adv[0] ? (bus.in_bmask & keep_mask) : (bmask_q[0] & keep_mask);
    for (int i = 1; i < STAGES; i++) begin
      bmask_d[i] = adv[i] ? (bmask_q[i-1] & keep_mask) : (bmask_q[i] & keep_mask);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        bmask_q[i] <= '0;
      end
    end else begin
      bmask_q <= bmask_d;
    end
  end

  assign bus.out_bmask = bmask_q[LAST];
`else
  logic unused_branch;

  assign kill          = '0;
  assign kill_in       = 1'b0;
  assign bus.out_bmask = '0;
  assign unused_branch = ^{bus.in_bmask, bus.squash_en, bus.squash_mask,
                           bus.resolve_en, bus.resolve_mask};
`endif

  logic [PW-1:0] product;
  assign product = psum_q[LAST];

  always_comb begin
    bus.out_result = '0;
    case (func_q[LAST])
      M_MUL:                    bus.out_result = product[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: bus.out_result = product[PW-1:XLEN];
      default:                  bus.out_result = '0;
    endcase
  end

  assign bus.out_valid = valid_q[LAST] && !kill[LAST];
  assign bus.out_tag   = tag_q[LAST];
endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: scoreboard of expected results, checked when out_valid is taken.
module tb_mult_pipe;
  localparam int XLEN    = 32;
  localparam int STAGES  = 4;
  localparam int TAG_W   = 6;
  localparam int BMASK_W = 4;
`ifdef MULT_PIPE_BRANCH_EN
  localparam bit BRANCH = 1'b1;
`else
  localparam bit BRANCH = 1'b0;
`endif

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mult_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W), .BMASK_W(BMASK_W)) bus ();

  mult_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .BMASK_W(BMASK_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0]  tag;
    logic [3:0]  bmask;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  int          cyc, n_checks, n_errors, n_outv;
  int          done_cyc [64];
  int          acc_cyc  [64];
  logic        last_rdy, last_acc, held_valid;
  logic [31:0] held_res, last_res;
  logic [5:0]  held_tag;
  logic [3:0]  held_bmask;

  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb_v;
    logic        [63:0] p;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin sa = $signed({{32{a[31]}}, a}); sb_v = $signed({{32{b[31]}}, b});
                  p = sa * sb_v; return p[63:32]; end
      3'd2: begin sa = $signed({{32{a[31]}}, a}); sb_v = $signed({32'b0, b});
                  p = sa * sb_v; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  task automatic step();
    exp_t       e;
    logic       kill_in;
    logic [3:0] clr;
    #1;
    last_rdy = bus.in_ready;
    if (BRANCH && bus.squash_en) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if ((sb[i].bmask & bus.squash_mask) != 4'h0) sb.delete(i);
      end
    end
    if (bus.out_valid) begin
      n_outv++;
      if (bus.stall) begin
        if (held_valid) begin
          chk("stall_hold_result", bus.out_result, held_res);
          chk("stall_hold_tag",    bus.out_tag,    held_tag);
          chk("stall_hold_bmask",  bus.out_bmask,  held_bmask);
        end
        held_valid = 1'b1;
        held_res   = bus.out_result;
        held_tag   = bus.out_tag;
        held_bmask = bus.out_bmask;
      end else begin
        held_valid = 1'b0;
        chk("out_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_tag",    bus.out_tag,    e.tag);
          chk("out_result", bus.out_result, e.res);
          chk("out_bmask",  bus.out_bmask,  e.bmask);
          last_res = bus.out_result;
          done_cyc[bus.out_tag] = cyc;
        end
      end
    end else begin
      held_valid = 1'b0;
    end
    clr = (BRANCH && bus.resolve_en) ? ~bus.resolve_mask : 4'hF;
    foreach (sb[i]) sb[i].bmask = sb[i].bmask & clr;
    kill_in  = BRANCH && bus.squash_en && ((bus.in_bmask & bus.squash_mask) != 4'h0);
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) begin
      acc_cyc[bus.in_tag] = cyc;
      if (!kill_in) begin
        e.tag   = bus.in_tag;
        e.bmask = BRANCH ? (bus.in_bmask & clr) : 4'h0;
        e.res   = ref_mul(bus.in_func, bus.in_rs1, bus.in_rs2);
        sb.push_back(e);
      end
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t, input logic [3:0] m);
    bus.in_valid = 1'b1;
    bus.in_func  = f;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_tag   = t;
    bus.in_bmask = m;
    step();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 40 && sb.size() > 0; k++) step();
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic clear_done();
    for (int i = 0; i < 64; i++) begin
      done_cyc[i] = -1;
      acc_cyc[i]  = -1;
    end
  endtask

  initial begin
    int t, outv0;
    n_checks = 0; n_errors = 0; n_outv = 0; cyc = 0;
    held_valid = 1'b0; last_res = '0; last_rdy = 1'b0; last_acc = 1'b0;
    bus.in_valid = 0; bus.in_func = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    bus.in_tag = 0; bus.in_bmask = 0; bus.stall = 0;
    bus.squash_en = 0; bus.squash_mask = 0; bus.resolve_en = 0; bus.resolve_mask = 0;
    clear_done();

    #1 reset = 1'b0;
    #2;
    chk("rst_out_valid",  bus.out_valid,  0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_tag",    bus.out_tag,    0);
    chk("rst_out_bmask",  bus.out_bmask,  0);
    chk("rst_in_ready",   bus.in_ready,   1);
    @(negedge clock);
    reset = 1'b1;

    // Single MUL then MULH on the reference operands.
    issue(M_MUL, 32'hff123456, 32'hfffff888, 6'd1, 4'h0);
    drain();
    chk("mul_const", last_res, 32'hF0091DB0);
    chk("mul_latency", done_cyc[1] - acc_cyc[1], STAGES);
    issue(M_MULH, 32'hff123456, 32'hfffff888, 6'd2, 4'h0);
    drain();
    chk("mulh_const", last_res, 32'h00000006);

    // Back-to-back MULHU.
    clear_done();
    for (int i = 1; i <= 4; i++) issue(M_MULHU, $urandom, $urandom, 6'(i), 4'h0);
    drain();
    chk("b2b_latency", done_cyc[1] - acc_cyc[1], STAGES);
    for (int i = 1; i < 4; i++) chk("b2b_consecutive", done_cyc[i+1] - done_cyc[i], 1);

    // Every func code, including undefined ones, with signed corner operands.
    issue(M_MUL,    32'h80000000, 32'h80000000, 6'd12, 4'h0);
    issue(M_MULH,   32'h80000000, 32'hffffffff, 6'd13, 4'h0);
    issue(M_MULHSU, 32'hfffffffe, 32'hffffffff, 6'd14, 4'h0);
    issue(M_MULHU,  32'hffffffff, 32'hffffffff, 6'd15, 4'h0);
    issue(3'd5,     $urandom,     $urandom,     6'd16, 4'h0);
    issue(M_MULHSU, $urandom,     $urandom,     6'd17, 4'h0);
    drain();

    // Three-cycle stall on a valid result while tags 2..5 arrive behind it.
    clear_done();
    issue(M_MUL, $urandom, $urandom, 6'd1, 4'h0);
    idle(STAGES - 1);
    bus.stall = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      issue(M_MULHU, $urandom, $urandom, 6'(i), 4'h0);
      chk("stall_ready", last_rdy, 1);
    end
    bus.stall = 1'b0;
    issue(M_MULH, $urandom, $urandom, 6'd5, 4'h0);
    chk("stall_ready", last_rdy, 1);
    drain();
    chk("stall_latency", done_cyc[1] - acc_cyc[1], STAGES + 3);
    chk("stall_fill_latency", done_cyc[2] - acc_cyc[2], STAGES);

    // Long stall: in_ready drops only once every stage is full.
    clear_done();
    issue(M_MUL, $urandom, $urandom, 6'd20, 4'h0);
    idle(STAGES - 1);
    bus.stall = 1'b1;
    t = 21;
    for (int k = 0; k < 5; k++) begin
      issue(M_MULHU, $urandom, $urandom, 6'(t), 4'h0);
      chk("long_stall_ready", last_rdy, (k < STAGES - 1));
      if (last_acc) t++;
    end
    bus.stall = 1'b0;
    for (int k = 0; k < 4 && t <= 24; k++) begin
      issue(M_MUL, $urandom, $urandom, 6'(t), 4'h0);
      if (last_acc) t++;
    end
    drain();
    chk("long_stall_latency", done_cyc[20] - acc_cyc[20], STAGES + 5);

    // Squash of an in-flight op.
    clear_done();
    issue(M_MUL, $urandom, $urandom, 6'd7, 4'b0010);
    issue(M_MUL, $urandom, $urandom, 6'd8, 4'b0001);
    bus.in_valid = 1'b0;
    bus.squash_en = 1'b1; bus.squash_mask = 4'b0010;
    step();
    bus.squash_en = 1'b0; bus.squash_mask = 4'b0000;
    drain();
    chk("squash_t7_done", done_cyc[7], BRANCH ? -1 : acc_cyc[7] + STAGES);
    chk("squash_t8_latency", done_cyc[8] - acc_cyc[8], STAGES);

    // Resolve then squash; same-cycle resolve+squash; squash at the input.
    clear_done();
    issue(M_MULHU, $urandom, $urandom, 6'd9, 4'b0010);
    bus.in_valid = 1'b0;
    bus.resolve_en = 1'b1; bus.resolve_mask = 4'b0010;
    step();
    bus.resolve_en = 1'b0;
    bus.squash_en = 1'b1; bus.squash_mask = 4'b0010;
    step();
    bus.squash_en = 1'b0;
    issue(M_MUL, $urandom, $urandom, 6'd10, 4'b0100);
    bus.in_valid = 1'b0;
    bus.resolve_en = 1'b1; bus.resolve_mask = 4'b0100;
    bus.squash_en  = 1'b1; bus.squash_mask  = 4'b0100;
    step();
    bus.resolve_en = 1'b0; bus.squash_mask = 4'b1000;
    issue(M_MUL, $urandom, $urandom, 6'd11, 4'b1000);
    bus.squash_en = 1'b0; bus.squash_mask = 4'b0000;
    drain();
    chk("resolve_t9_latency", done_cyc[9] - acc_cyc[9], STAGES);
    chk("same_cycle_t10_done", done_cyc[10], BRANCH ? -1 : acc_cyc[10] + STAGES);
    chk("input_squash_t11_done", done_cyc[11], BRANCH ? -1 : acc_cyc[11] + STAGES);

    // Reset with three ops in flight.
    issue(M_MUL, $urandom, $urandom, 6'd30, 4'h1);
    issue(M_MULH, $urandom, $urandom, 6'd31, 4'h2);
    issue(M_MULHU, $urandom, $urandom, 6'd32, 4'h4);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid",  bus.out_valid,  0);
    chk("mid_rst_out_result", bus.out_result, 0);
    chk("mid_rst_out_tag",    bus.out_tag,    0);
    chk("mid_rst_out_bmask",  bus.out_bmask,  0);
    chk("mid_rst_in_ready",   bus.in_ready,   1);
    sb.delete();
    held_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    outv0 = n_outv;
    idle(STAGES + 3);
    chk("post_rst_no_out", n_outv - outv0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
